// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel 8-bit PWM LED driver.
// Colour changes (jump or linear fade) are applied only at period boundaries,
// so every PWM period is generated with one consistent set of duties.
// No FSM and no handshake: light is a level input, sampled only at a wrap.
module rgb_pwm_driver #(
  parameter int PRESCALE = 1,
  parameter int FADE     = 0,
  parameter int STEP     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        pwm_r,
  output logic        pwm_g,
  output logic        pwm_b,
  output logic        frame,
  output logic        busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre;
  logic [7:0]    cnt;
  logic [7:0]    duty_r, duty_g, duty_b;
  logic          tick;
  logic          wrap;

  assign tick = enable && (pre == PW'(PRESCALE - 1));
  assign wrap = tick && (cnt == 8'hFF);

  // One fade step toward tgt; 9-bit math keeps the step from wrapping or overshooting.
  function automatic logic [7:0] fade_step(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] c9, t9, s9;
    c9 = {1'b0, cur};
    t9 = {1'b0, tgt};
    s9 = 9'(STEP);
    if (t9 >= c9) begin
      if ((t9 - c9) <= s9) return tgt;
      else                 return 8'(c9 + s9);
    end else begin
      if ((c9 - t9) <= s9) return tgt;
      else                 return 8'(c9 - s9);
    end
  endfunction

  // Next applied duty for a channel: direct load or one fade step.
  function automatic logic [7:0] next_duty(input logic [7:0] cur, input logic [7:0] tgt);
    if (FADE != 0) return fade_step(cur, tgt);
    else           return tgt;
  endfunction

  // Prescaler: divides the clock down to PWM counter ticks; held at 0 while disabled.
  always_ff @(posedge clk) begin
    if (rst || !enable) pre <= '0;
    else if (tick)      pre <= '0;
    else                pre <= pre + PW'(1);
  end

  // PWM counter: free-running 8-bit ramp, natural 255->0 wrap marks the boundary.
  always_ff @(posedge clk) begin
    if (rst || !enable) cnt <= 8'd0;
    else if (tick)      cnt <= cnt + 8'd1;
  end

  // Applied duties: only move at a boundary, so a period is never torn.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_r <= 8'd0;
      duty_g <= 8'd0;
      duty_b <= 8'd0;
    end else if (wrap) begin
      duty_r <= next_duty(duty_r, light[23:16]);
      duty_g <= next_duty(duty_g, light[15:8]);
      duty_b <= next_duty(duty_b, light[7:0]);
    end
  end

  // Registered pin drives and boundary pulse, computed from pre-edge cnt/duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
      frame <= 1'b0;
    end else begin
      pwm_r <= enable && (cnt < duty_r);
      pwm_g <= enable && (cnt < duty_g);
      pwm_b <= enable && (cnt < duty_b);
      frame <= wrap;
    end
  end

  // Busy while any applied duty still differs from its requested channel.
  assign busy = (duty_r != light[23:16]) | (duty_g != light[15:8]) | (duty_b != light[7:0]);

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: three instances (plain, fading, prescaled).
// Pin high times per period are measured and compared against a scoreboard.
module tb_rgb_pwm_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v   [3];
  logic        en_v    [3];
  logic [23:0] light_v [3];
  logic        pr [3];
  logic        pg [3];
  logic        pb [3];
  logic        fr [3];
  logic        bz [3];

  // u0: direct load, u1: fade STEP=16, u2: PRESCALE=3
  rgb_pwm_driver #(.PRESCALE(1), .FADE(0), .STEP(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .enable(en_v[0]), .light(light_v[0]),
    .pwm_r(pr[0]), .pwm_g(pg[0]), .pwm_b(pb[0]), .frame(fr[0]), .busy(bz[0]));
  rgb_pwm_driver #(.PRESCALE(1), .FADE(1), .STEP(16)) u1 (
    .clk(clk), .rst(rst_v[1]), .enable(en_v[1]), .light(light_v[1]),
    .pwm_r(pr[1]), .pwm_g(pg[1]), .pwm_b(pb[1]), .frame(fr[1]), .busy(bz[1]));
  rgb_pwm_driver #(.PRESCALE(3), .FADE(0), .STEP(1)) u2 (
    .clk(clk), .rst(rst_v[2]), .enable(en_v[2]), .light(light_v[2]),
    .pwm_r(pr[2]), .pwm_g(pg[2]), .pwm_b(pb[2]), .frame(fr[2]), .busy(bz[2]));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [29:0] exp_q[$];

  function automatic logic [29:0] rgb3(input int r, input int g, input int b);
    return {10'(r), 10'(g), 10'(b)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [29:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check_period(input string tag, input logic [29:0] got);
    logic [29:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed %0h expected queued entry", tag, got);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(got), 32'(e));
    end
  endtask

  // ---------------- driver / monitor tasks ----------------
  // Counts negedges until instance k shows frame; n=-1 when the bound expires.
  task automatic wait_frame(input int k, input int limit, output int n, output logic [29:0] got);
    int hr, hg, hb;
    hr = 0; hg = 0; hb = 0; n = -1;
    for (int j = 1; j <= limit; j++) begin
      @(negedge clk);
      hr += int'(pr[k]); hg += int'(pg[k]); hb += int'(pb[k]);
      if (fr[k]) begin
        n = j;
        break;
      end
    end
    got = rgb3(hr, hg, hb);
  endtask

  // Measures one period starting at a frame cycle: pin high counts over the
  // next len cycles, frame must appear exactly on the last of them.
  task automatic measure(input int k, input int len, input int chg_at, input logic [23:0] chg_val,
                         output logic [29:0] got, output logic frame_ok);
    int hr, hg, hb;
    hr = 0; hg = 0; hb = 0; frame_ok = 1'b1;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      if (j == chg_at) light_v[k] = chg_val;
      hr += int'(pr[k]); hg += int'(pg[k]); hb += int'(pb[k]);
      if (j < len && fr[k])   frame_ok = 1'b0;
      if (j == len && !fr[k]) frame_ok = 1'b0;
    end
    got = rgb3(hr, hg, hb);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int          n;
    int          frames;
    logic [29:0] got;
    logic        fok;
    logic        any_pin;

    for (int k = 0; k < 3; k++) begin
      rst_v[k] = 1'b1;
      en_v[k]  = 1'b1;
    end
    light_v[0] = 24'hFF8000;
    light_v[1] = 24'h282000;
    light_v[2] = 24'h0A0000;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // reset state
    chk("rst_pins", {29'd0, pr[0] | pg[0] | pb[0]}, 32'd0);
    chk("rst_frame", {31'd0, fr[0]}, 32'd0);
    chk("rst_busy", {31'd0, bz[0]}, 32'd1);

    // ---- u0: first period dark, frame at clk 256 ----
    rst_v[0] = 1'b0;
    wait_frame(0, 1000, n, got);
    chk("u0_first_frame_clk", 32'(n), 32'd256);
    chk("u0_first_period_dark", 32'(got), 32'(rgb3(0, 0, 0)));
    chk("u0_busy_after_load", {31'd0, bz[0]}, 32'd0);

    push_exp(rgb3(255, 128, 0));
    measure(0, 256, -1, 24'h0, got, fok);
    check_period("u0_ff8000", got);
    chk("u0_period_256", {31'd0, fok}, 32'd1);

    // mid-period change at cnt=100: old duties hold for this period
    push_exp(rgb3(255, 128, 0));
    push_exp(rgb3(0, 0, 64));
    measure(0, 256, 100, 24'h000040, got, fok);
    check_period("u0_torn_guard", got);
    chk("u0_busy_after_change", {31'd0, bz[0]}, 32'd0);
    measure(0, 256, -1, 24'h0, got, fok);
    check_period("u0_000040", got);

    // ---- u0: drop enable mid-period ----
    repeat (50) @(negedge clk);
    chk("u0_pin_b_before_drop", {31'd0, pb[0]}, 32'd1);
    en_v[0] = 1'b0;
    @(negedge clk);
    chk("u0_pins_after_drop", {29'd0, pr[0] | pg[0] | pb[0]}, 32'd0);
    frames = 0;
    any_pin = 1'b0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clk);
      frames += int'(fr[0]);
      any_pin |= pr[0] | pg[0] | pb[0];
    end
    chk("u0_no_frame_disabled", 32'(frames), 32'd0);
    chk("u0_dark_disabled", {31'd0, any_pin}, 32'd0);
    en_v[0] = 1'b1;
    wait_frame(0, 1000, n, got);
    chk("u0_reenable_frame_clk", 32'(n), 32'd256);
    push_exp(rgb3(0, 0, 64));
    measure(0, 256, -1, 24'h0, got, fok);
    check_period("u0_duty_kept", got);

    // ---- u1: fade STEP=16 ----
    rst_v[1] = 1'b0;
    wait_frame(1, 1000, n, got);
    chk("u1_first_frame_clk", 32'(n), 32'd256);
    chk("u1_busy_fading", {31'd0, bz[1]}, 32'd1);
    push_exp(rgb3(16, 16, 0));
    push_exp(rgb3(32, 32, 0));
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_up1", got);
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_up2", got);
    chk("u1_busy_done_up", {31'd0, bz[1]}, 32'd0);
    light_v[1] = 24'h000000;
    push_exp(rgb3(40, 32, 0));
    push_exp(rgb3(24, 16, 0));
    push_exp(rgb3(8, 0, 0));
    push_exp(rgb3(0, 0, 0));
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_up3", got);
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_down1", got);
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_down2", got);
    chk("u1_busy_done_down", {31'd0, bz[1]}, 32'd0);
    light_v[1] = 24'hFFFFFF;
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_down3", got);

    // reset mid-fade
    repeat (100) @(negedge clk);
    rst_v[1] = 1'b1;
    @(negedge clk);
    chk("u1_rst_pins", {29'd0, pr[1] | pg[1] | pb[1]}, 32'd0);
    chk("u1_rst_frame", {31'd0, fr[1]}, 32'd0);
    chk("u1_rst_busy", {31'd0, bz[1]}, 32'd1);
    rst_v[1] = 1'b0;
    wait_frame(1, 1000, n, got);
    chk("u1_rst_frame_clk", 32'(n), 32'd256);
    chk("u1_rst_duty_zero", 32'(got), 32'(rgb3(0, 0, 0)));
    push_exp(rgb3(16, 16, 16));
    measure(1, 256, -1, 24'h0, got, fok);
    check_period("u1_refade", got);

    // ---- u2: PRESCALE=3 ----
    rst_v[2] = 1'b0;
    wait_frame(2, 2000, n, got);
    chk("u2_first_frame_clk", 32'(n), 32'd768);
    push_exp(rgb3(30, 0, 0));
    measure(2, 768, -1, 24'h0, got, fok);
    check_period("u2_duty10", got);
    chk("u2_period_768", {31'd0, fok}, 32'd1);

    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
